// File: rtl/mercury_tank.sv
// mercury_tank: one EDSAC mercury delay-line tank modelled as a serial store.
// The stored word train recirculates one digit per clk. Per-tank gates from
// the Control Section write (t_in), clear (t_clr) or read (t_out) the digit
// that is currently passing the tank's read/write point.
// Optional feature: define MERCURY_TANK_DEBUG_EN to add a combinational
// parallel readback of one minor cycle (dbg_minor -> dbg_word).
module mercury_tank #(
  parameter int DIGITS = 18,
  parameter int MINORS = 32
) (
  input  logic              clk,
  input  logic              reset_neg,
  input  logic              sync,
  input  logic              mib,
  input  logic              t_in,
  input  logic              t_out,
  input  logic              t_clr,
`ifdef MERCURY_TANK_DEBUG_EN
  input  logic [4:0]        dbg_minor,
  output logic [DIGITS-1:0] dbg_word,
`endif
  output logic              mob,
  output logic [4:0]        pos_digit,
  output logic [4:0]        pos_minor,
  output logic              slip,
  output logic              slip_seen
);

  localparam int TANK_LEN = DIGITS * MINORS;
  localparam int PW       = $clog2(TANK_LEN);

  // Whole tank contents. Kept in flops rather than RAM because reset must
  // clear every bit at once.
  logic [TANK_LEN-1:0] store_reg;
  logic [TANK_LEN-1:0] store_next;

  logic [4:0]    digit_reg;
  logic [4:0]    digit_next;
  logic [4:0]    minor_reg;
  logic [4:0]    minor_next;
  logic          mob_reg;
  logic          mob_next;
  logic          slip_reg;
  logic          slip_next;
  logic          slip_seen_reg;
  logic          slip_seen_next;

  logic [PW-1:0] pos_lin;
  logic [PW-1:0] eff_pos;
  logic          old_bit;
  logic          new_bit;

  // Linear position; a sync pulse away from position 0 forces this clk to act as position 0
  always_comb begin
    pos_lin   = PW'(minor_reg) * PW'(DIGITS) + PW'(digit_reg);
    slip_next = sync && (pos_lin != '0);
    eff_pos   = slip_next ? '0 : pos_lin;
  end

  // Position counters: digit wraps into minor; a slip restarts the count just past position 0
  always_comb begin
    digit_next = digit_reg + 5'd1;
    minor_next = minor_reg;
    if (slip_next) begin
      digit_next = 5'd1;
      minor_next = 5'd0;
    end else if (digit_reg == 5'(DIGITS - 1)) begin
      digit_next = 5'd0;
      minor_next = (minor_reg == 5'(MINORS - 1)) ? 5'd0 : minor_reg + 5'd1;
    end
  end

  // Read the pre-write bit, then write it back, replaced or cleared (t_in wins over t_clr)
  always_comb begin
    old_bit             = store_reg[eff_pos];
    new_bit             = t_in ? mib : (t_clr ? 1'b0 : old_bit);
    mob_next            = t_out & old_bit;
    slip_seen_next      = slip_seen_reg | slip_next;
    store_next          = store_reg;
    store_next[eff_pos] = new_bit;
  end

  // State registers; asynchronous reset drops any in-flight write and clears the tank
  always_ff @(posedge clk or negedge reset_neg) begin
    if (!reset_neg) begin
      store_reg     <= '0;
      digit_reg     <= 5'd0;
      minor_reg     <= 5'd0;
      mob_reg       <= 1'b0;
      slip_reg      <= 1'b0;
      slip_seen_reg <= 1'b0;
    end else begin
      store_reg     <= store_next;
      digit_reg     <= digit_next;
      minor_reg     <= minor_next;
      mob_reg       <= mob_next;
      slip_reg      <= slip_next;
      slip_seen_reg <= slip_seen_next;
    end
  end

  assign mob       = mob_reg;
  assign pos_digit = digit_reg;
  assign pos_minor = minor_reg;
  assign slip      = slip_reg;
  assign slip_seen = slip_seen_reg;

`ifdef MERCURY_TANK_DEBUG_EN
  // Parallel readback taps the storage directly and never touches circulation.
  logic          dbg_valid;
  logic [PW-1:0] dbg_base;

  assign dbg_valid = (int'(dbg_minor) < MINORS);
  assign dbg_base  = dbg_valid ? PW'(dbg_minor) * PW'(DIGITS) : '0;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dbg
    assign dbg_word[gi] = dbg_valid & store_reg[dbg_base + PW'(gi)];
  end
`endif

endmodule

// File: tb/tb_mercury_tank.sv
// Testbench for mercury_tank: directed slot table, hand-written corner
// sequences (gate priority, slip, reset) and randomized traffic, all checked
// against a linear-address model of the tank.
module tb_mercury_tank;

  localparam int DIGITS = 18;
  localparam int MINORS = 32;
  localparam int LEN    = DIGITS * MINORS;

  logic       clk = 1'b0;
  logic       reset_neg = 1'b1;
  logic       sync = 1'b0;
  logic       mib = 1'b0;
  logic       t_in = 1'b0;
  logic       t_out = 1'b0;
  logic       t_clr = 1'b0;
  logic       mob;
  logic [4:0] pos_digit;
  logic [4:0] pos_minor;
  logic       slip;
  logic       slip_seen;
`ifdef MERCURY_TANK_DEBUG_EN
  logic [4:0]        dbg_minor = 5'd0;
  logic [DIGITS-1:0] dbg_word;
`endif

  mercury_tank #(.DIGITS(DIGITS), .MINORS(MINORS)) dut (
    .clk       (clk),
    .reset_neg (reset_neg),
    .sync      (sync),
    .mib       (mib),
    .t_in      (t_in),
    .t_out     (t_out),
    .t_clr     (t_clr),
`ifdef MERCURY_TANK_DEBUG_EN
    .dbg_minor (dbg_minor),
    .dbg_word  (dbg_word),
`endif
    .mob       (mob),
    .pos_digit (pos_digit),
    .pos_minor (pos_minor),
    .slip      (slip),
    .slip_seen (slip_seen)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: a flat bit array addressed by one linear position.
  bit m_mem [LEN];
  int m_pos;
  bit m_mob;
  bit m_slip;
  bit m_seen;

  typedef struct {
    int          minor;
    logic [17:0] data;
    bit          wr;
    bit          clr;
    bit          rd;
    int          exp;
  } slot_vec_t;

  slot_vec_t vecs [10];

  task automatic model_reset();
    for (int i = 0; i < LEN; i++) m_mem[i] = 1'b0;
    m_pos  = 0;
    m_mob  = 1'b0;
    m_slip = 1'b0;
    m_seen = 1'b0;
  endtask

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic check_cycle();
    checks++;
    if (mob !== m_mob || slip !== m_slip || slip_seen !== m_seen ||
        pos_digit !== 5'(m_pos % DIGITS) || pos_minor !== 5'(m_pos / DIGITS)) begin
      failures++;
      $display("FAIL cycle t=%0t got mob=%b slip=%b seen=%b digit=%0d minor=%0d expected mob=%b slip=%b seen=%b digit=%0d minor=%0d",
               $time, mob, slip, slip_seen, pos_digit, pos_minor,
               m_mob, m_slip, m_seen, m_pos % DIGITS, m_pos / DIGITS);
    end
  endtask

  // One digit period: drive inputs, clock, advance the model, compare.
  task automatic step(bit s, bit d, bit wi, bit ro, bit wc);
    int eff;
    sync  = s;
    mib   = d;
    t_in  = wi;
    t_out = ro;
    t_clr = wc;
    @(posedge clk);
    m_slip = s && (m_pos != 0);
    eff    = m_slip ? 0 : m_pos;
    m_seen = m_seen | m_slip;
    m_mob  = ro & m_mem[eff];
    if (wi)      m_mem[eff] = d;
    else if (wc) m_mem[eff] = 1'b0;
    m_pos = (eff + 1) % LEN;
    #1;
    check_cycle();
  endtask

  // Idle until the model says the next clk processes position target.
  task automatic idle_to(int target, bit ro);
    for (int i = 0; i < LEN && m_pos != target; i++) step(1'b0, 1'b0, 1'b0, ro, 1'b0);
  endtask

  // Run one whole minor-cycle slot with the given gates; collect mob LSB-first.
  task automatic run_slot(int minor, logic [17:0] data, bit wr, bit clr, bit rd, output int got);
    idle_to(minor * DIGITS, 1'b0);
    got = 0;
    for (int d = 0; d < DIGITS; d++) begin
      step(1'b0, data[d], wr, rd, clr);
      got |= int'(mob) << d;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int ones;

    vecs[0] = '{3, 18'h2A5A5, 1'b1, 1'b0, 1'b1, 'h00000};
    vecs[1] = '{3, 18'h00000, 1'b0, 1'b0, 1'b1, 'h2A5A5};
    vecs[2] = '{4, 18'h00000, 1'b0, 1'b0, 1'b1, 'h00000};
    vecs[3] = '{7, 18'h13579, 1'b1, 1'b0, 1'b1, 'h00000};
    vecs[4] = '{7, 18'h00000, 1'b0, 1'b0, 1'b1, 'h13579};
    vecs[5] = '{7, 18'h3FFFF, 1'b0, 1'b1, 1'b1, 'h13579};
    vecs[6] = '{7, 18'h00000, 1'b0, 1'b0, 1'b1, 'h00000};
    vecs[7] = '{3, 18'h00000, 1'b0, 1'b0, 1'b1, 'h2A5A5};
    vecs[8] = '{3, 18'h00F0F, 1'b1, 1'b1, 1'b1, 'h2A5A5};
    vecs[9] = '{3, 18'h00000, 1'b0, 1'b0, 1'b1, 'h00F0F};

    // Reset state
    #2 reset_neg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_mob", int'(mob), 0);
    check("reset_slip", int'(slip), 0);
    check("reset_seen", int'(slip_seen), 0);
    check("reset_pos", int'({pos_minor, pos_digit}), 0);
    @(negedge clk);
    reset_neg = 1'b1;
    model_reset();

    // Empty tank: one full circulation reading zeros, then wrap to 0/0
    ones = 0;
    for (int i = 0; i < LEN; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      ones += int'(mob);
    end
    check("empty_ones", ones, 0);
    check("wrap_digit", int'(pos_digit), 0);
    check("wrap_minor", int'(pos_minor), 0);
    $display("empty circulation: ones=%0d pos=%0d/%0d", ones, pos_minor, pos_digit);

    // Table of whole-slot writes / clears / reads
    for (int v = 0; v < 10; v++) begin
      run_slot(vecs[v].minor, vecs[v].data, vecs[v].wr, vecs[v].clr, vecs[v].rd, got);
      check($sformatf("slot_vec%0d", v), got, vecs[v].exp);
      $display("slot vec%0d minor=%0d wr=%b clr=%b rd=%b mob=0x%05h", v, vecs[v].minor,
               vecs[v].wr, vecs[v].clr, vecs[v].rd, got);
    end
`ifdef MERCURY_TANK_DEBUG_EN
    dbg_minor = 5'd3;
    #1;
    check("dbg_minor3", int'(dbg_word), 'h00F0F);
`endif

    // t_in and t_clr together at minor 5 digit 2: mib wins, same-clk read sees old 0
    idle_to(5 * DIGITS + 2, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("both_gates_old", int'(mob), 0);
    idle_to(5 * DIGITS + 2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("both_gates_new", int'(mob), 1);
    $display("both gates at m5 d2: readback=%b", mob);

    // Sync at p=100 with a write: acts on position 0
    idle_to(100, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("slip_pulse", int'(slip), 1);
    check("slip_seen_set", int'(slip_seen), 1);
    check("slip_digit", int'(pos_digit), 1);
    check("slip_minor", int'(pos_minor), 0);
    check("slip_read_p0", int'(mob), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("slip_one_clk", int'(slip), 0);
    check("slip_sticky", int'(slip_seen), 1);
    run_slot(0, 18'h0, 1'b0, 1'b0, 1'b1, got);
    check("slip_write_p0", got, 'h00001);
    run_slot(5, 18'h0, 1'b0, 1'b0, 1'b1, got);
    check("slip_minor5", got, 'h00004);
    run_slot(3, 18'h0, 1'b0, 1'b0, 1'b1, got);
    check("slip_minor3", got, 'h00F0F);
    $display("slip at p=100: minor0=0x%05h", 1);

    // Sync exactly at position 0: no slip
    idle_to(0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sync_p0_noslip", int'(slip), 0);
    check("sync_p0_digit", int'(pos_digit), 1);
    $display("sync at p=0: slip=%b", slip);

    // Randomized gates, data and occasional sync
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
           1'($urandom), ($urandom_range(0, 5) == 0));
    end
    $display("random phase: checks=%0d failures=%0d", checks, failures);

    // Reset mid-circulation, with a write and sync in flight
    idle_to(3 * DIGITS, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_to(3 * DIGITS, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pre_reset_mob", int'(mob), 1);
    sync  = 1'b1;
    t_in  = 1'b1;
    mib   = 1'b1;
    t_out = 1'b1;
    #2 reset_neg = 1'b0;
    #1;
    check("async_mob", int'(mob), 0);
    check("async_seen", int'(slip_seen), 0);
    check("async_pos", int'({pos_minor, pos_digit}), 0);
    repeat (3) @(posedge clk);
    #1;
    check("held_pos", int'({pos_minor, pos_digit}), 0);
    check("held_slip", int'(slip), 0);
    sync = 1'b0;
    t_in = 1'b0;
    mib  = 1'b0;
    @(negedge clk);
    reset_neg = 1'b1;
    model_reset();
    ones = 0;
    for (int i = 0; i < LEN; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      ones += int'(mob);
    end
    check("post_reset_ones", ones, 0);
    check("post_reset_seen", int'(slip_seen), 0);
    $display("reset mid-circulation: ones after release=%0d", ones);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
